// File: rtl/priv_mtimer_pkg.sv
// Shared definitions for the machine-timer bank.
//   reg_idx_e  : word index of each register in the CSR-facing map
//   ctrl_t     : layout of the CTRL register (en in bit 0, latch_mode in bits 15:8)
//   helpers    : register count, compare-channel index lookup, parameter legality
package priv_mtimer_pkg;

  localparam int unsigned MAX_CMP = 8;

  typedef enum int unsigned {
    REG_TIME_LO  = 0,
    REG_TIME_HI  = 1,
    REG_PRESC    = 2,
    REG_CTRL     = 3,
    REG_IP       = 4,
    REG_CMP_BASE = 5
  } reg_idx_e;

  typedef struct packed {
    logic [15:0] rsvd_hi;
    logic [7:0]  latch_mode;
    logic [6:0]  rsvd_lo;
    logic        en;
  } ctrl_t;

  function automatic int unsigned num_regs(input int unsigned num_cmp);
    return 32'(REG_CMP_BASE) + 2 * num_cmp;
  endfunction

  function automatic int unsigned cmp_lo_idx(input int unsigned k);
    return 32'(REG_CMP_BASE) + 2 * k;
  endfunction

  function automatic int unsigned cmp_hi_idx(input int unsigned k);
    return 32'(REG_CMP_BASE) + 2 * k + 1;
  endfunction

  function automatic bit cfg_legal(input int unsigned cnt_w, input int unsigned num_cmp);
    return (cnt_w >= 32) && (cnt_w <= 64) && (num_cmp >= 1) && (num_cmp <= MAX_CMP);
  endfunction

endpackage

// File: rtl/priv_mtimer_bank_if.sv
// Word-indexed register port between the CSR register file (master) and the
// timer bank (slave).
//   reg_idx   : register index, width covers 5 + 2*NUM_CMP registers
//   wen/ren   : one-cycle write / read strobes
//   wdata     : write data
//   rdata     : combinational read data for reg_idx
//   valid_idx : reg_idx maps to an implemented register
// Handshake: no back-pressure. A strobe is accepted in the cycle it is high;
// rdata/valid_idx are valid in the same cycle reg_idx is presented.
interface priv_mtimer_bank_if #(
  parameter int unsigned NUM_CMP = 2
);
  localparam int unsigned IDX_W = $clog2(5 + 2 * NUM_CMP);

  logic [IDX_W-1:0] reg_idx;
  logic             wen;
  logic             ren;
  logic [31:0]      wdata;
  logic [31:0]      rdata;
  logic             valid_idx;

  modport master (
    output reg_idx, wen, ren, wdata,
    input  rdata, valid_idx
  );

  modport slave (
    input  reg_idx, wen, ren, wdata,
    output rdata, valid_idx
  );
endinterface

// File: rtl/priv_timer_prescaler.sv
// Prescaler for the machine timer.
//   CLK, nRST : clock, async active-low reset
//   en, halt  : counting runs only while en & ~halt
//   clear     : synchronous clear of the prescale count (has priority)
//   presc     : terminal value; a tick is issued when the count equals it
//   tick      : one-cycle pulse, advances the main counter
module priv_timer_prescaler #(
  parameter int unsigned PRESC_W = 8
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic               en,
  input  logic               halt,
  input  logic               clear,
  input  logic [PRESC_W-1:0] presc,
  output logic               tick
);
  logic [PRESC_W-1:0] presc_cnt;
  logic               run;

  assign run  = en & ~halt;
  // presc == 0 gives a tick every running cycle.
  assign tick = run & (presc_cnt == presc);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      presc_cnt <= '0;
    end else if (clear || tick) begin
      presc_cnt <= '0;
    end else if (run) begin
      presc_cnt <= presc_cnt + PRESC_W'(1);
    end
  end
endmodule

// File: rtl/priv_mtimer_bank.sv
// Machine-timer bank: free-running counter with prescaler and NUM_CMP
// compare channels, each raising its own interrupt.
//   CLK, nRST : clock, async active-low reset
//   bus       : CSR register port (slave side)
//   halt      : debug halt, freezes counter and prescaler
//   timer_irq : per-channel interrupt, registered
//   irq_any   : OR of timer_irq, registered
module priv_mtimer_bank
  import priv_mtimer_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 64,
  parameter int unsigned NUM_CMP   = 2,
  parameter int unsigned PRESC_W   = 8
) (
  input  logic                 CLK,
  input  logic                 nRST,
  priv_mtimer_bank_if.slave    bus,
  input  logic                 halt,
  output logic [NUM_CMP-1:0]   timer_irq,
  output logic                 irq_any
);

  if (!cfg_legal(CNT_WIDTH, NUM_CMP)) begin : g_cfg_check
    $error("priv_mtimer_bank: CNT_WIDTH must be 32..64 and NUM_CMP 1..8");
  end

  // High halves of time/compare only exist when the counter is wider than 32.
  localparam bit          HAS_HI     = (CNT_WIDTH > 32);
  localparam int unsigned NREGS      = num_regs(NUM_CMP);
  localparam logic [7:0]  LATCH_MASK = 8'((1 << NUM_CMP) - 1);

  logic [CNT_WIDTH-1:0] count;
  logic [63:0]          count_ext;
  logic [31:0]          hi_snap;
  logic [31:0]          cmp_shadow;
  logic [PRESC_W-1:0]   presc;
  ctrl_t                ctrl;
  logic [NUM_CMP-1:0]   ip;
  logic [CNT_WIDTH-1:0] cmp [NUM_CMP];

  logic [31:0]          idx;
  logic                 wr_time_lo, wr_time_hi, wr_time;
  logic                 wr_presc, wr_ctrl, wr_ip, wr_shadow, snap_en;
  logic [NUM_CMP-1:0]   cmp_commit;
  logic [63:0]          time_wr;
  logic [63:0]          cmp_wide;
  ctrl_t                ctrl_wr;
  logic                 en_n;
  logic [NUM_CMP-1:0]   hit, ip_n, irq_n;
  logic                 tick;

  assign count_ext = 64'(count);

  // Write/strobe decode.
  always_comb begin
    idx        = 32'(bus.reg_idx);
    wr_time_lo = bus.wen && (idx == REG_TIME_LO);
    wr_time_hi = bus.wen && (idx == REG_TIME_HI) && HAS_HI;
    wr_time    = wr_time_lo || wr_time_hi;
    wr_presc   = bus.wen && (idx == REG_PRESC);
    wr_ctrl    = bus.wen && (idx == REG_CTRL);
    wr_ip      = bus.wen && (idx == REG_IP);
    snap_en    = bus.ren && (idx == REG_TIME_LO);
    wr_shadow  = 1'b0;
    cmp_commit = '0;
    for (int k = 0; k < NUM_CMP; k++) begin
      if (HAS_HI) begin
        // LO only parks in the shadow; HI commits the full value at once.
        if (bus.wen && (idx == cmp_lo_idx(k))) wr_shadow = 1'b1;
        cmp_commit[k] = bus.wen && (idx == cmp_hi_idx(k));
      end else begin
        cmp_commit[k] = bus.wen && (idx == cmp_lo_idx(k));
      end
    end
  end

  always_comb begin
    time_wr = count_ext;
    if (wr_time_lo) time_wr[31:0]  = bus.wdata;
    if (wr_time_hi) time_wr[63:32] = bus.wdata;
    cmp_wide = HAS_HI ? {bus.wdata, cmp_shadow} : {32'h0, bus.wdata};
  end

  always_comb begin
    ctrl_wr            = '0;
    ctrl_wr.en         = bus.wdata[0];
    ctrl_wr.latch_mode = bus.wdata[15:8] & LATCH_MASK;
    en_n               = wr_ctrl ? ctrl_wr.en : ctrl.en;
  end

  // Interrupt pending: level channels follow hit; latched channels hold until
  // W1C or a compare commit, with a concurrent hit taking precedence.
  always_comb begin
    for (int k = 0; k < NUM_CMP; k++) begin
      hit[k] = (count >= cmp[k]);
      if (ctrl.latch_mode[k]) begin
        ip_n[k] = ip[k];
        if (cmp_commit[k] || (wr_ip && bus.wdata[k])) ip_n[k] = 1'b0;
        if (hit[k]) ip_n[k] = 1'b1;
      end else begin
        ip_n[k] = hit[k];
      end
    end
    irq_n = ip_n & {NUM_CMP{en_n}};
  end

  priv_timer_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_presc (
    .CLK   (CLK),
    .nRST  (nRST),
    .en    (ctrl.en),
    .halt  (halt),
    .clear (wr_presc || wr_time),
    .presc (presc),
    .tick  (tick)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      count      <= '0;
      hi_snap    <= '0;
      cmp_shadow <= '0;
      presc      <= '0;
      ctrl       <= '0;
      ip         <= '0;
      timer_irq  <= '0;
      irq_any    <= 1'b0;
      for (int k = 0; k < NUM_CMP; k++) cmp[k] <= '1;
    end else begin
      // A software time write overrides a coincident tick.
      if (wr_time)    count <= time_wr[CNT_WIDTH-1:0];
      else if (tick)  count <= count + CNT_WIDTH'(1);
      if (snap_en)    hi_snap <= count_ext[63:32];
      if (wr_presc)   presc <= bus.wdata[PRESC_W-1:0];
      if (wr_ctrl)    ctrl <= ctrl_wr;
      if (wr_shadow)  cmp_shadow <= bus.wdata;
      for (int k = 0; k < NUM_CMP; k++) begin
        if (cmp_commit[k]) cmp[k] <= cmp_wide[CNT_WIDTH-1:0];
      end
      ip        <= ip_n;
      timer_irq <= irq_n;
      irq_any   <= |irq_n;
    end
  end

  // Read mux: always the pre-write view of the addressed register.
  always_comb begin
    logic [63:0] c64;
    c64           = '0;
    bus.rdata     = '0;
    bus.valid_idx = (idx < NREGS);
    if (idx == REG_TIME_LO)      bus.rdata = count_ext[31:0];
    else if (idx == REG_TIME_HI) bus.rdata = hi_snap;
    else if (idx == REG_PRESC)   bus.rdata = 32'(presc);
    else if (idx == REG_CTRL)    bus.rdata = ctrl;
    else if (idx == REG_IP)      bus.rdata = 32'(ip);
    else begin
      for (int k = 0; k < NUM_CMP; k++) begin
        c64 = 64'(cmp[k]);
        if (idx == cmp_lo_idx(k)) bus.rdata = c64[31:0];
        if (idx == cmp_hi_idx(k)) bus.rdata = c64[63:32];
      end
    end
  end

endmodule

// File: tb/tb_priv_mtimer_bank.sv
module tb_priv_mtimer_bank;

  localparam int unsigned NUM_CMP = 2;

  localparam logic [3:0] I_TLO = 4'd0, I_THI = 4'd1, I_PRE = 4'd2, I_CTL = 4'd3, I_IP = 4'd4;
  localparam logic [3:0] I_C0L = 4'd5, I_C0H = 4'd6, I_C1L = 4'd7, I_C1H = 4'd8;

  typedef struct {
    logic        wr;
    logic        ren;
    logic [3:0]  idx;
    logic [31:0] data;
    logic [31:0] exp;
    logic        exp_v;
  } vec_t;

  logic               CLK;
  logic               nRST;
  logic               halt;
  logic [NUM_CMP-1:0] timer_irq;
  logic               irq_any;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];
  vec_t        tbl[$];

  priv_mtimer_bank_if #(.NUM_CMP(NUM_CMP)) bus ();

  priv_mtimer_bank #(
    .CNT_WIDTH (64),
    .NUM_CMP   (NUM_CMP),
    .PRESC_W   (8)
  ) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .bus       (bus),
    .halt      (halt),
    .timer_irq (timer_irq),
    .irq_any   (irq_any)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  function automatic vec_t mk(input logic wr, input logic ren, input logic [3:0] idx,
                              input logic [31:0] data, input logic [31:0] exp, input logic exp_v);
    vec_t v;
    v.wr = wr; v.ren = ren; v.idx = idx; v.data = data; v.exp = exp; v.exp_v = exp_v;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called just after a negedge; one cycle per write.
  task automatic write_reg(input logic [3:0] idx, input logic [31:0] data);
    bus.reg_idx = idx;
    bus.wdata   = data;
    bus.wen     = 1'b1;
    bus.ren     = 1'b0;
    @(negedge CLK);
    bus.wen = 1'b0;
  endtask

  // Expected value enters the scoreboard when the read is driven and is
  // popped when rdata is sampled; consumes one cycle.
  task automatic read_check(input string name, input logic [3:0] idx, input logic r,
                            input logic [31:0] exp, input logic exp_v);
    logic [31:0] e;
    bus.reg_idx = idx;
    bus.ren     = r;
    bus.wen     = 1'b0;
    exp_q.push_back(exp);
    #1;
    if (exp_q.size() == 0) begin
      check({name, "_queue"}, 64'd0, 64'd1);
    end else begin
      e = exp_q.pop_front();
      check(name, 64'(bus.rdata), 64'(e));
      check({name, "_valid"}, 64'(bus.valid_idx), 64'(exp_v));
    end
    @(negedge CLK);
    bus.ren = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] m_cnt;
    int          m_pc;
    logic        m_irq;
    logic        new_ip;

    nRST = 1'b0; halt = 1'b0;
    bus.reg_idx = '0; bus.wen = 1'b0; bus.ren = 1'b0; bus.wdata = '0;
    repeat (3) @(negedge CLK);
    #1;
    check("reset_irq", 64'(timer_irq), 64'd0);
    check("reset_irq_any", 64'(irq_any), 64'd0);
    @(negedge CLK);
    nRST = 1'b1;

    // ---- register table (counter disabled) ----
    tbl.push_back(mk(0, 1, I_TLO, 0, 32'h0,        1));
    tbl.push_back(mk(0, 0, I_THI, 0, 32'h0,        1));
    tbl.push_back(mk(0, 0, I_PRE, 0, 32'h0,        1));
    tbl.push_back(mk(0, 0, I_CTL, 0, 32'h0,        1));
    tbl.push_back(mk(0, 0, I_IP,  0, 32'h0,        1));
    tbl.push_back(mk(0, 0, I_C0L, 0, 32'hFFFFFFFF, 1));
    tbl.push_back(mk(0, 0, I_C0H, 0, 32'hFFFFFFFF, 1));
    tbl.push_back(mk(0, 0, I_C1L, 0, 32'hFFFFFFFF, 1));
    tbl.push_back(mk(0, 0, I_C1H, 0, 32'hFFFFFFFF, 1));
    tbl.push_back(mk(0, 0, 4'd9,  0, 32'h0,        0));
    tbl.push_back(mk(0, 0, 4'd15, 0, 32'h0,        0));
    tbl.push_back(mk(1, 0, I_PRE, 32'h1234, 0, 0));
    tbl.push_back(mk(0, 0, I_PRE, 0, 32'h34,       1));
    tbl.push_back(mk(1, 0, I_CTL, 32'hFFFFFF00, 0, 0));
    tbl.push_back(mk(0, 0, I_CTL, 0, 32'h300,      1));
    tbl.push_back(mk(1, 0, 4'd9,  32'hDEAD, 0, 0));
    tbl.push_back(mk(0, 0, 4'd9,  0, 32'h0,        0));
    tbl.push_back(mk(1, 0, I_C1L, 32'h11112222, 0, 0));
    tbl.push_back(mk(0, 0, I_C1L, 0, 32'hFFFFFFFF, 1));
    tbl.push_back(mk(1, 0, I_C1H, 32'h3, 0, 0));
    tbl.push_back(mk(0, 0, I_C1L, 0, 32'h11112222, 1));
    tbl.push_back(mk(0, 0, I_C1H, 0, 32'h3,        1));
    tbl.push_back(mk(1, 0, I_THI, 32'h5, 0, 0));
    tbl.push_back(mk(1, 0, I_TLO, 32'h77, 0, 0));
    tbl.push_back(mk(0, 1, I_TLO, 0, 32'h77,       1));
    tbl.push_back(mk(0, 0, I_THI, 0, 32'h5,        1));
    tbl.push_back(mk(0, 0, I_IP,  0, 32'h2,        1));
    tbl.push_back(mk(1, 0, I_CTL, 32'h0, 0, 0));
    tbl.push_back(mk(1, 0, I_THI, 32'h0, 0, 0));
    tbl.push_back(mk(0, 0, I_CTL, 0, 32'h0,        1));
    tbl.push_back(mk(0, 0, I_IP,  0, 32'h0,        1));
    foreach (tbl[i]) begin
      if (tbl[i].wr) write_reg(tbl[i].idx, tbl[i].data);
      else read_check($sformatf("tbl[%0d]", i), tbl[i].idx, tbl[i].ren, tbl[i].exp, tbl[i].exp_v);
    end

    // ---- prescaled counting, level irq on ch0 ----
    write_reg(I_TLO, 32'h0);
    write_reg(I_C0L, 32'd10);
    write_reg(I_C0H, 32'h0);
    write_reg(I_PRE, 32'd3);
    write_reg(I_CTL, 32'h1);
    m_cnt = 0; m_pc = 0; m_irq = 1'b0;
    for (int i = 0; i < 50; i++) begin
      #1;
      check($sformatf("presc_irq0[%0d]", i), 64'(timer_irq[0]), 64'(m_irq));
      read_check($sformatf("presc_cnt[%0d]", i), I_TLO, 1'b0, m_cnt, 1'b1);
      new_ip = (m_cnt >= 32'd10);
      if (m_pc == 3) begin m_pc = 0; m_cnt = m_cnt + 1; end
      else m_pc = m_pc + 1;
      m_irq = new_ip;
    end

    // ---- latched ch1 survives time rewrite, W1C clears; halt freezes ----
    halt = 1'b1;
    write_reg(I_CTL, 32'h0);
    write_reg(I_THI, 32'h0);
    write_reg(I_TLO, 32'h0);
    write_reg(I_PRE, 32'h0);
    write_reg(I_C1L, 32'd5);
    write_reg(I_C1H, 32'h0);
    write_reg(I_CTL, 32'h201);
    halt = 1'b0;
    idle(10);
    halt = 1'b1;
    write_reg(I_TLO, 32'h0);
    idle(3);
    #1;
    check("latch_irq_held", 64'(timer_irq), 64'h2);
    check("latch_irq_any", 64'(irq_any), 64'h1);
    read_check("latch_ip", I_IP, 1'b0, 32'h2, 1'b1);
    write_reg(I_IP, 32'h2);
    idle(1);
    #1;
    check("w1c_irq", 64'(timer_irq), 64'h0);
    check("w1c_irq_any", 64'(irq_any), 64'h0);
    idle(20);
    read_check("halt_lo", I_TLO, 1'b1, 32'h0, 1'b1);
    read_check("halt_hi", I_THI, 1'b0, 32'h0, 1'b1);
    halt = 1'b0;
    idle(5);
    read_check("post_halt_lo", I_TLO, 1'b0, 32'd5, 1'b1);

    // ---- atomic hi/lo read across the 32-bit carry ----
    halt = 1'b1;
    write_reg(I_CTL, 32'h1);
    write_reg(I_THI, 32'h0);
    write_reg(I_TLO, 32'hFFFFFFFF);
    halt = 1'b0;
    read_check("atom_lo0", I_TLO, 1'b1, 32'hFFFFFFFF, 1'b1);
    read_check("atom_hi0", I_THI, 1'b0, 32'h0, 1'b1);
    read_check("atom_lo1", I_TLO, 1'b1, 32'h1, 1'b1);
    read_check("atom_hi1", I_THI, 1'b0, 32'h1, 1'b1);

    // ---- compare LO/HI commit: no glitch through the half-written value ----
    halt = 1'b1;
    write_reg(I_C1L, 32'hFFFFFFFF);
    write_reg(I_C1H, 32'hFFFFFFFF);
    write_reg(I_THI, 32'h0);
    write_reg(I_TLO, 32'hFFFFFFF0);
    write_reg(I_C0L, 32'hFFFFFFFF);
    write_reg(I_C0H, 32'h0);
    idle(2);
    #1;
    check("cmp_setup_irq0", 64'(timer_irq[0]), 64'd0);
    write_reg(I_C0L, 32'h0);
    for (int i = 0; i < 2; i++) begin
      #1;
      check($sformatf("cmp_lo_only_irq0[%0d]", i), 64'(timer_irq[0]), 64'd0);
      @(negedge CLK);
    end
    write_reg(I_C0H, 32'h1);
    for (int i = 0; i < 2; i++) begin
      #1;
      check($sformatf("cmp_commit_irq0[%0d]", i), 64'(timer_irq[0]), 64'd0);
      @(negedge CLK);
    end
    halt = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge CLK);
      #1;
      check($sformatf("cross_irq0[%0d]", n), 64'(timer_irq[0]), 64'(n >= 17));
    end
    @(negedge CLK);

    // ---- time write in a tick cycle wins; prescaler restarts ----
    halt = 1'b1;
    write_reg(I_THI, 32'h0);
    write_reg(I_TLO, 32'h0);
    write_reg(I_PRE, 32'd3);
    halt = 1'b0;
    idle(3);
    write_reg(I_TLO, 32'h100);
    read_check("tickwr_0", I_TLO, 1'b0, 32'h100, 1'b1);
    idle(2);
    read_check("tickwr_3", I_TLO, 1'b0, 32'h100, 1'b1);
    read_check("tickwr_4", I_TLO, 1'b0, 32'h101, 1'b1);

    // ---- full-width wrap keeps a latched IP ----
    halt = 1'b1;
    write_reg(I_CTL, 32'h201);
    write_reg(I_PRE, 32'h0);
    write_reg(I_C1L, 32'h10);
    write_reg(I_C1H, 32'h0);
    write_reg(I_THI, 32'hFFFFFFFF);
    write_reg(I_TLO, 32'hFFFFFFFF);
    idle(2);
    halt = 1'b0;
    idle(4);
    #1;
    check("wrap_latched_irq1", 64'(timer_irq[1]), 64'd1);
    read_check("wrap_lo", I_TLO, 1'b1, 32'h3, 1'b1);
    read_check("wrap_hi", I_THI, 1'b0, 32'h0, 1'b1);

    // ---- simultaneous write and read of the same register ----
    halt = 1'b1;
    write_reg(I_TLO, 32'h42);
    bus.reg_idx = I_TLO; bus.wdata = 32'h99; bus.wen = 1'b1; bus.ren = 1'b1;
    exp_q.push_back(32'h42);
    #1;
    check("wr_rd_same_pre", 64'(bus.rdata), 64'(exp_q.pop_front()));
    @(negedge CLK);
    bus.wen = 1'b0; bus.ren = 1'b0;
    read_check("wr_rd_same_post", I_TLO, 1'b0, 32'h99, 1'b1);

    // ---- asynchronous reset mid-run drops an uncommitted compare half ----
    halt = 1'b0;
    write_reg(I_C0L, 32'h1234);
    idle(2);
    #2;
    nRST = 1'b0;
    #1;
    check("midrst_irq", 64'(timer_irq), 64'd0);
    check("midrst_irq_any", 64'(irq_any), 64'd0);
    @(negedge CLK);
    read_check("midrst_lo", I_TLO, 1'b1, 32'h0, 1'b1);
    read_check("midrst_hi", I_THI, 1'b0, 32'h0, 1'b1);
    read_check("midrst_presc", I_PRE, 1'b0, 32'h0, 1'b1);
    read_check("midrst_ctrl", I_CTL, 1'b0, 32'h0, 1'b1);
    read_check("midrst_ip", I_IP, 1'b0, 32'h0, 1'b1);
    read_check("midrst_c0l", I_C0L, 1'b0, 32'hFFFFFFFF, 1'b1);
    read_check("midrst_c1h", I_C1H, 1'b0, 32'hFFFFFFFF, 1'b1);
    nRST = 1'b1;
    write_reg(I_C0H, 32'h0);
    read_check("shadow_cleared_lo", I_C0L, 1'b0, 32'h0, 1'b1);
    read_check("shadow_cleared_hi", I_C0H, 1'b0, 32'h0, 1'b1);
    idle(3);
    read_check("post_rst_stopped", I_TLO, 1'b0, 32'h0, 1'b1);

    // ---- final report ----
    if (exp_q.size() != 0) check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
